// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: fetch/decode/execute/memory/write-back sequencing, IR, C/Z flags, return-stack pointer.
// Optional build macro STACK_CHECK_EN: stack over/underflow traps to FAULT instead of wrapping.
module multicycle_controller #(
    parameter int unsigned INSTR_W     = 19,
    parameter int unsigned STACK_DEPTH = 8,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               sh_c,
    input  logic               sh_z,
    output logic [INSTR_W-1:0] ir,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               mem_write,
    output logic               ir_load,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         pc_mux,
    output logic [1:0]         reg_write_mux,
    output logic               alu_in_mux,
    output logic               reg_B_mux,
    output logic               alu_use_carry,
    output logic [2:0]         alu_op,
    output logic               push,
    output logic               pop,
    output logic               C,
    output logic               Z,
    output logic [SP_W-1:0]    sp,
    output logic               halted,
    output logic               fault
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt, StFault
    } state_e;

    state_e             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_c, r_z;
    logic [SP_W-1:0]    r_sp;

    logic [4:0]      w_op;
    logic            w_is_arith, w_is_shift, w_is_mem, w_is_br;
    logic            w_is_jmp, w_is_jsb, w_is_ret, w_is_halt;
    logic            w_br_take, w_stk_err;
    logic [SP_W-1:0] w_sp_inc, w_sp_dec;

    assign w_op       = r_ir[INSTR_W-1 -: 5];
    assign w_is_arith = ~w_op[4];
    assign w_is_shift = (w_op[4:2] == 3'b110);
    assign w_is_mem   = (w_op[4:2] == 3'b100);
    assign w_is_br    = (w_op[4:2] == 3'b101);
    assign w_is_jmp   = (w_op == 5'b11100);
    assign w_is_jsb   = (w_op == 5'b11101);
    assign w_is_ret   = (w_op == 5'b11110);
    assign w_is_halt  = (w_op == 5'b11111);
    assign w_br_take  = (w_op[1] ? r_c : r_z) ^ w_op[0];

    // Occupancy runs 0..STACK_DEPTH, so wrap is modulo STACK_DEPTH+1
    assign w_sp_inc = (r_sp == SP_W'(STACK_DEPTH)) ? '0 : r_sp + 1'b1;
    assign w_sp_dec = (r_sp == '0) ? SP_W'(STACK_DEPTH) : r_sp - 1'b1;

`ifdef STACK_CHECK_EN
    assign w_stk_err = (w_is_jsb && (r_sp == SP_W'(STACK_DEPTH))) || (w_is_ret && (r_sp == '0));
`else
    assign w_stk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
            r_ir    <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_sp    <= '0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (imem_ready) begin
                        r_ir    <= instr_in;
                        r_state <= StDecode;
                    end
                end
                StDecode: r_state <= w_is_halt ? StHalt : StExec;
                StExec: begin
                    r_state <= StFetch;
                    if (w_is_arith) begin
                        r_c <= alu_c;
                        r_z <= alu_z;
                    end else if (w_is_shift) begin
                        r_c <= sh_c;
                        r_z <= sh_z;
                    end else if (w_is_mem) begin
                        r_state <= StMem;
                    end else if (w_stk_err) begin
                        r_state <= StFault;
                    end else if (w_is_jsb) begin
                        r_sp <= w_sp_inc;
                    end else if (w_is_ret) begin
                        r_sp <= w_sp_dec;
                    end
                end
                StMem: begin
                    if (dmem_ready) r_state <= w_op[0] ? StFetch : StWb;
                end
                StWb:    r_state <= StFetch;
                StHalt:  r_state <= StHalt;
                StFault: r_state <= StFault;
                default: r_state <= StFetch;
            endcase
        end
    end

    assign ir = r_ir;
    assign C  = r_c;
    assign Z  = r_z;
    assign sp = r_sp;

    // Strobes are gated by reset so the fetch request drops the moment reset asserts
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        mem_write     = 1'b0;
        ir_load       = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        pc_mux        = 2'b00;
        reg_write_mux = 2'b00;
        alu_in_mux    = 1'b0;
        reg_B_mux     = 1'b0;
        alu_use_carry = 1'b0;
        alu_op        = 3'b000;
        push          = 1'b0;
        pop           = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        if (reset) begin
            unique case (r_state)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                    pc_write = imem_ready;
                end
                StExec: begin
                    if (w_is_arith) begin
                        alu_op        = w_op[2:0];
                        alu_use_carry = w_op[0];
                        alu_in_mux    = w_op[3];
                        reg_write     = 1'b1;
                    end else if (w_is_shift) begin
                        reg_write_mux = 2'b01;
                        reg_write     = 1'b1;
                    end else if (w_is_mem) begin
                        alu_in_mux = 1'b1;
                        reg_B_mux  = 1'b1;
                    end else if (w_is_br) begin
                        pc_write = w_br_take;
                        pc_mux   = w_br_take ? 2'b01 : 2'b00;
                    end else if (w_is_jmp) begin
                        pc_write = 1'b1;
                        pc_mux   = 2'b10;
                    end else if (w_is_jsb && !w_stk_err) begin
                        push     = 1'b1;
                        pc_write = 1'b1;
                        pc_mux   = 2'b10;
                    end else if (w_is_ret && !w_stk_err) begin
                        pop      = 1'b1;
                        pc_write = 1'b1;
                        pc_mux   = 2'b11;
                    end
                end
                StMem: begin
                    dmem_req  = 1'b1;
                    mem_write = w_op[0];
                end
                StWb: begin
                    reg_write     = 1'b1;
                    reg_write_mux = 2'b10;
                end
                StHalt: halted = 1'b1;
`ifdef STACK_CHECK_EN
                StFault: fault = 1'b1;
`else
                StFault: fault = 1'b0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-level reference model.
module tb_multicycle_controller;

    localparam int IW    = 19;
    localparam int DEPTH = 2;
    localparam int SPW   = $clog2(DEPTH) + 1;
`ifdef STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic       imem_req, dmem_req, mem_write, ir_load, pc_write, reg_write;
        logic [1:0] pc_mux, reg_write_mux;
        logic       alu_in_mux, reg_B_mux, alu_use_carry;
        logic [2:0] alu_op;
        logic       push, pop, halted, fault;
    } strobes_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [IW-1:0]   instr_in;
    logic            imem_ready, dmem_ready, alu_c, alu_z, sh_c, sh_z;
    logic [IW-1:0]   ir;
    logic            imem_req, dmem_req, mem_write, ir_load, pc_write, reg_write;
    logic [1:0]      pc_mux, reg_write_mux;
    logic            alu_in_mux, reg_B_mux, alu_use_carry;
    logic [2:0]      alu_op;
    logic            push, pop, C, Z, halted, fault;
    logic [SPW-1:0]  sp;
    strobes_t        obs;

    assign obs = {imem_req, dmem_req, mem_write, ir_load, pc_write, reg_write, pc_mux,
                  reg_write_mux, alu_in_mux, reg_B_mux, alu_use_carry, alu_op, push, pop,
                  halted, fault};

    multicycle_controller #(.INSTR_W(IW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_c(alu_c), .alu_z(alu_z), .sh_c(sh_c), .sh_z(sh_z),
        .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write), .pc_mux(pc_mux),
        .reg_write_mux(reg_write_mux), .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux),
        .alu_use_carry(alu_use_carry), .alu_op(alu_op), .push(push), .pop(pop),
        .C(C), .Z(Z), .sp(sp), .halted(halted), .fault(fault)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state
    logic          m_c, m_z;
    int            m_sp;
    logic [IW-1:0] m_ir;
    bit            m_stuck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic noise();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        instr_in   = IW'($urandom);
        alu_c      = 1'($urandom);
        alu_z      = 1'($urandom);
        sh_c       = 1'($urandom);
        sh_z       = 1'($urandom);
    endtask

    // Called at a negedge; asserts reset mid-cycle and releases it on a later negedge
    task automatic do_reset();
        #2 reset = 1'b0;
        noise();
        #1;
        check("rst_out", 32'(obs), 32'd0);
        check("rst_regs", 32'({ir, C, Z, sp}), 32'd0);
        @(negedge clk);
        noise();
        #1;
        check("rst_hold", 32'(obs), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        m_c     = 1'b0;
        m_z     = 1'b0;
        m_sp    = 0;
        m_ir    = '0;
        m_stuck = 1'b0;
    endtask

    // One full instruction; fl < 0 randomizes flag inputs, else fl[1]=carry, fl[0]=zero
    task automatic run_instr(input logic [4:0] op, input int iw, input int dw, input int fl);
        logic [IW-1:0] instr;
        strobes_t      e;
        logic          nc, nz, cond;
        bit            to_mem, to_fault;
        instr = {op, (IW-5)'($urandom)};
        for (int i = 0; i < iw; i++) begin
            noise();
            imem_ready = 1'b0;
            #1;
            e = '0; e.imem_req = 1'b1;
            check("fetch_wait", 32'(obs), 32'(e));
            check("ir_hold", 32'(ir), 32'(m_ir));
            @(negedge clk);
        end
        noise();
        imem_ready = 1'b1;
        instr_in   = instr;
        #1;
        e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
        check("fetch", 32'(obs), 32'(e));
        @(negedge clk);
        m_ir = instr;
        noise();
        #1;
        check("ir_load", 32'(ir), 32'(m_ir));
        check("decode", 32'(obs), 32'd0);
        @(negedge clk);
        if (op == 5'h1f) begin
            for (int i = 0; i < 3; i++) begin
                noise();
                #1;
                e = '0; e.halted = 1'b1;
                check("halt", 32'(obs), 32'(e));
                @(negedge clk);
            end
            m_stuck = 1'b1;
            return;
        end
        noise();
        if (fl >= 0) begin
            alu_c = fl[1]; alu_z = fl[0];
            sh_c  = fl[1]; sh_z  = fl[0];
        end
        #1;
        e = '0; nc = m_c; nz = m_z; to_mem = 1'b0; to_fault = 1'b0;
        if (!op[4]) begin
            e.alu_op = op[2:0]; e.alu_use_carry = op[0]; e.alu_in_mux = op[3];
            e.reg_write = 1'b1;
            nc = alu_c; nz = alu_z;
        end else begin
            case (op[3:2])
                2'b10: begin
                    e.reg_write_mux = 2'b01; e.reg_write = 1'b1;
                    nc = sh_c; nz = sh_z;
                end
                2'b00: begin
                    e.alu_in_mux = 1'b1; e.reg_B_mux = 1'b1;
                    to_mem = 1'b1;
                end
                2'b01: begin
                    cond = (op[1] ? m_c : m_z) ^ op[0];
                    if (cond) begin
                        e.pc_write = 1'b1; e.pc_mux = 2'b01;
                    end
                end
                default: begin
                    if (op[1:0] == 2'b00) begin
                        e.pc_write = 1'b1; e.pc_mux = 2'b10;
                    end else if (op[1:0] == 2'b01) begin
                        if (CHK && m_sp == DEPTH) to_fault = 1'b1;
                        else begin
                            e.push = 1'b1; e.pc_write = 1'b1; e.pc_mux = 2'b10;
                            m_sp = (m_sp + 1) % (DEPTH + 1);
                        end
                    end else begin
                        if (CHK && m_sp == 0) to_fault = 1'b1;
                        else begin
                            e.pop = 1'b1; e.pc_write = 1'b1; e.pc_mux = 2'b11;
                            m_sp = (m_sp + DEPTH) % (DEPTH + 1);
                        end
                    end
                end
            endcase
        end
        check("exec", 32'(obs), 32'(e));
        @(negedge clk);
        m_c = nc;
        m_z = nz;
        check("flags", 32'({C, Z}), 32'({m_c, m_z}));
        check("sp", 32'(sp), 32'(m_sp));
        if (to_fault) begin
            for (int i = 0; i < 3; i++) begin
                noise();
                #1;
                e = '0; e.fault = 1'b1;
                check("fault", 32'(obs), 32'(e));
                check("sp_frozen", 32'(sp), 32'(m_sp));
                @(negedge clk);
            end
            m_stuck = 1'b1;
            return;
        end
        if (to_mem) begin
            for (int i = 0; i <= dw; i++) begin
                noise();
                dmem_ready = (i == dw);
                #1;
                e = '0; e.dmem_req = 1'b1; e.mem_write = op[0];
                check("mem", 32'(obs), 32'(e));
                @(negedge clk);
            end
            if (!op[0]) begin
                noise();
                #1;
                e = '0; e.reg_write = 1'b1; e.reg_write_mux = 2'b10;
                check("wb", 32'(obs), 32'(e));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [4:0] op;
        reset = 1'b0;
        noise();
        #1;
        check("por_out", 32'(obs), 32'd0);
        check("por_regs", 32'({ir, C, Z, sp}), 32'd0);
        @(negedge clk);
        do_reset();

        // ADDC with carry set and zero clear, zero-wait fetch
        run_instr(5'b00001, 0, 0, 2);
        check("addc_c", 32'(C), 32'd1);
        check("addc_z", 32'(Z), 32'd0);
        // LDM with two fetch waits and one data wait
        run_instr(5'b10000, 2, 1, -1);
        run_instr(5'b10001, 1, 2, -1);
        // BNZ taken when Z=0, not taken when Z=1
        run_instr(5'b00000, 0, 0, 0);
        run_instr(5'b10101, 0, 0, -1);
        run_instr(5'b00000, 0, 0, 1);
        run_instr(5'b10101, 0, 0, -1);

        // Three JSBs from empty stack
        do_reset();
        for (int i = 0; i < 3 && !m_stuck; i++) run_instr(5'b11101, 0, 0, -1);
        do_reset();
        // RET on empty stack
        run_instr(5'b11110, 0, 0, -1);
        if (!CHK) check("ret_wrap", 32'(sp), 32'(DEPTH));
        check("ret_fault", 32'(fault), 32'(CHK));
        do_reset();

        // HALT, then reset and resume
        run_instr(5'b11111, 1, 0, -1);
        check("halted", 32'(halted), 32'd1);
        do_reset();
        run_instr(5'b11000, 0, 0, 3);

        // Reset while a fetch is waiting
        noise();
        imem_ready = 1'b0;
        do_reset();

        for (int n = 0; n < 300; n++) begin
            op = 5'($urandom);
            if (op == 5'h1f && $urandom_range(0, 7) != 0) op = 5'h08;
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), -1);
            if (m_stuck) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
